// File: rtl/video_char_sink_pkg.sv
// Shared constants and FSM encoding for the CPU-to-VGA character sink.
package video_char_sink_pkg;
    localparam int SCREEN_CELLS_DEF = 1200;
    localparam int ADDR_W_DEF       = 11;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int CHAR_W           = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } vcs_state_t;
endpackage

// File: rtl/video_write_fifo.sv
// Small synchronous write queue; head entry is read combinationally.
module video_write_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 27,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = storage[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) storage[wr_ptr] <= din;
    end
endmodule

// File: rtl/video_char_sink.sv
// CPU video-write responder: strobe detect, write queue, character RAM with
// a post-reset clear pass, and a 1-cycle scan read port for the renderer.
module video_char_sink
    import video_char_sink_pkg::*;
#(
    parameter int SCREEN_CELLS = SCREEN_CELLS_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wire_videoflag,
    input  logic [15:0]       bus_vga_pos,
    input  logic [15:0]       bus_vga_char,
    input  logic              scan_rd_en,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [15:0]       scan_data,
    output logic              scan_valid,
    output logic              fifo_full,
    output logic              busy,
    output logic              overflow,
    output logic              range_err,
    input  logic              err_clear
);
    localparam int ENTRY_W = ADDR_W + CHAR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(SCREEN_CELLS - 1);
    localparam logic [15:0]       CELLS_POS = 16'(SCREEN_CELLS);

    vcs_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  clear_cnt;
    logic               flag_d;
    logic               wr_event, pos_bad, accept;
    logic               q_push, q_pop, q_full, q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [ENTRY_W-1:0] q_din, q_dout;
    logic               scan_oob;
    logic               mem_we, mem_re;
    logic [ADDR_W-1:0]  mem_addr;
    logic [CHAR_W-1:0]  mem_wdata, mem_q;
    logic               scan_zero_q;
    logic [CHAR_W-1:0]  mem [SCREEN_CELLS];

    assign wr_event = wire_videoflag && !flag_d;
    assign pos_bad  = (bus_vga_pos >= CELLS_POS);
    assign accept   = wr_event && !pos_bad;
    assign scan_oob = (scan_addr > LAST_CELL);
    assign q_pop    = (state == RUN) && !scan_rd_en && !q_empty;
    assign q_push   = accept && (!q_full || q_pop);
    assign q_din    = {bus_vga_pos[ADDR_W-1:0], bus_vga_char};

    video_write_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clear_cnt <= clear_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clear_cnt == LAST_CELL) state_nxt = RUN;
    end

    // Single-port RAM: one operation per cycle, scan read beats queue drain.
    always_comb begin
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = scan_addr;
        mem_wdata = q_dout[CHAR_W-1:0];
        case (state)
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clear_cnt;
                mem_wdata = '0;
            end
            RUN: begin
                if (scan_rd_en) begin
                    mem_re = !scan_oob;
                end else if (!q_empty) begin
                    mem_we   = 1'b1;
                    mem_addr = q_dout[ENTRY_W-1:CHAR_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we)      mem[mem_addr] <= mem_wdata;
        else if (mem_re) mem_q <= mem[mem_addr];
    end

    // Reads that skip the RAM (clear pass, out-of-range) report zero via this flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flag_d      <= 1'b0;
            scan_valid  <= 1'b0;
            scan_zero_q <= 1'b1;
            overflow    <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            flag_d     <= wire_videoflag;
            scan_valid <= scan_rd_en;
            if (scan_rd_en) scan_zero_q <= (state == CLEAR) || scan_oob;
            overflow  <= (accept && q_full && !q_pop) || (overflow && !err_clear);
            range_err <= (wr_event && pos_bad) || (range_err && !err_clear);
        end
    end

    assign scan_data = scan_zero_q ? '0 : mem_q;
    assign fifo_full = q_full;

    assert property (@(posedge clock) disable iff (!reset) q_count <= CNT_W'(FIFO_DEPTH));
endmodule

// File: tb/tb_video_char_sink.sv
// Bench for video_char_sink: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_video_char_sink;
    localparam int CELLS = 1200;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vf = 1'b0;
    logic [15:0] pos = '0;
    logic [15:0] chr = '0;
    logic        rd = 1'b0;
    logic [10:0] addr = '0;
    logic        err_clear = 1'b0;
    logic [15:0] scan_data;
    logic        scan_valid, fifo_full, busy, overflow, range_err;

    video_char_sink dut (
        .clock          (clock),
        .reset          (reset),
        .wire_videoflag (vf),
        .bus_vga_pos    (pos),
        .bus_vga_char   (chr),
        .scan_rd_en     (rd),
        .scan_addr      (addr),
        .scan_data      (scan_data),
        .scan_valid     (scan_valid),
        .fifo_full      (fifo_full),
        .busy           (busy),
        .overflow       (overflow),
        .range_err      (range_err),
        .err_clear      (err_clear)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cells as an int array, the queue as a SV queue.
    int          m_mem [CELLS];
    logic [31:0] m_q [$];
    logic [31:0] m_e;
    int          m_clear_left = CELLS;
    bit          m_flag_d = 0, m_ovf = 0, m_rerr = 0, m_valid = 0;
    int          m_data = 0;
    bit          m_ev, m_busy, m_pop, m_full, m_ovf_set, m_rerr_set;
    bit          chk_en = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_clear_left = CELLS;
            m_flag_d = 0; m_ovf = 0; m_rerr = 0; m_valid = 0; m_data = 0;
            foreach (m_mem[i]) m_mem[i] = 0;
        end else begin
            m_ev     = vf && !m_flag_d;
            m_flag_d = vf;
            m_busy   = m_clear_left > 0;
            m_full   = m_q.size() == DEPTH;
            m_pop    = !m_busy && !rd && m_q.size() > 0;
            if (rd) begin
                m_valid = 1;
                m_data  = (m_busy || addr >= CELLS) ? 0 : m_mem[addr];
            end else begin
                m_valid = 0;
            end
            if (m_pop) begin
                m_e = m_q.pop_front();
                m_mem[m_e[31:16]] = int'(m_e[15:0]);
            end
            if (m_busy) begin
                m_mem[CELLS - m_clear_left] = 0;
                m_clear_left--;
            end
            m_rerr_set = m_ev && pos >= CELLS;
            m_ovf_set  = m_ev && pos < CELLS && m_full && !m_pop;
            if (m_ev && pos < CELLS && !m_ovf_set) m_q.push_back({pos, chr});
            m_rerr = m_rerr_set || (m_rerr && !err_clear);
            m_ovf  = m_ovf_set  || (m_ovf  && !err_clear);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy",       busy,       int'(m_clear_left > 0));
            chk("fifo_full",  fifo_full,  int'(m_q.size() == DEPTH));
            chk("overflow",   overflow,   m_ovf);
            chk("range_err",  range_err,  m_rerr);
            chk("scan_valid", scan_valid, m_valid);
            chk("scan_data",  scan_data,  m_data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input int p, input int c, input int hold);
        vf = 1'b1; pos = 16'(p); chr = 16'(c);
        repeat (hold) tick();
        vf = 1'b0;
        tick();
    endtask

    task automatic read_cell(input int a, input int exp);
        rd = 1'b1; addr = 11'(a);
        tick();
        chk("read_valid", scan_valid, 1);
        chk("read_data", scan_data, exp);
        rd = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("reset_busy", busy, 1);
        chk("reset_full", fifo_full, 0);
        tick(); tick();
        reset = 1'b1;
    endtask

    int n;

    initial begin
        #2 reset = 1'b0;
        #1 chk_en = 1;
        chk("rst_busy", busy, 1);
        chk("rst_valid", scan_valid, 0);
        chk("rst_data", scan_data, 0);
        chk("rst_ovf", overflow, 0);
        tick(); tick();
        reset = 1'b1;
        wait_clear(n);
        chk("clear_len", n, CELLS);
        read_cell(0, 0);
        read_cell(599, 0);
        read_cell(1199, 0);

        // Held strobe gives one write.
        strobe(10, 16'h0A41, 5);
        tick();
        read_cell(10, 16'h0A41);
        chk("t2_full", fifo_full, 0);

        // Five events during the clear pass: fifth overflows.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            strobe(i, 16'h1100 + i, 1);
            if (i == 4) chk("t3_full", fifo_full, 1);
        end
        chk("t3_ovf", overflow, 1);
        wait_clear(n);
        chk("t3_clear_len", n < 2000, 1);
        repeat (5) tick();
        for (int i = 1; i <= 4; i++) read_cell(i, 16'h1100 + i);
        read_cell(5, 0);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("t3_ovf_clr", overflow, 0);

        // Reads hold off the queue; commits follow in order.
        rd = 1'b1; addr = 11'd20;
        tick();
        strobe(20, 16'hB001, 1);
        strobe(21, 16'hB002, 1);
        strobe(20, 16'hB003, 1);
        repeat (13) tick();
        chk("t4_no_pop", scan_data, 0);
        rd = 1'b0;
        repeat (3) tick();
        read_cell(20, 16'hB003);
        read_cell(21, 16'hB002);

        // Range errors and err_clear priority.
        strobe(1200, 16'hDEAD, 1);
        chk("t5_rerr", range_err, 1);
        read_cell(1199, 0);
        vf = 1'b1; pos = 16'd1300; err_clear = 1'b1;
        tick();
        err_clear = 1'b0; vf = 1'b0;
        tick();
        chk("t5_rerr_win", range_err, 1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("t5_rerr_clr", range_err, 0);
        read_cell(2000, 0);

        // Reset with queued writes discards them.
        rd = 1'b1; addr = 11'd0;
        strobe(30, 16'hC030, 1);
        strobe(31, 16'hC031, 1);
        do_reset();
        rd = 1'b0;
        wait_clear(n);
        chk("t6_clear_len", n, CELLS);
        repeat (3) tick();
        read_cell(30, 0);
        read_cell(31, 0);

        // Randomized traffic, one mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500) begin
                reset = 1'b0; tick(); reset = 1'b1;
            end
            vf = ($urandom_range(0, 2) == 0) ? ~vf : vf;
            pos = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1190, 1310))
                                               : 16'($urandom_range(0, 15));
            chr = 16'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(1195, 2047))
                                                : 11'($urandom_range(0, 15));
            err_clear = ($urandom_range(0, 19) == 0);
            tick();
        end
        vf = 1'b0; rd = 1'b0; err_clear = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
